// File: rtl/cache_pkg.sv
// cache_pkg: width constants, state encoding and address-field helpers shared by
// the cache controller and its bus interface.
package cache_pkg;

    localparam int unsigned ADDR_BITS        = 32;
    localparam int unsigned WORD_BITS        = 32;
    localparam int unsigned TAG_BITS         = 22;
    localparam int unsigned LINE_INDEX_WIDTH = 6;
    localparam int unsigned LINE_WORDS_WIDTH = 2;
    localparam int unsigned WORD_BYTES_WIDTH = 2;

    // Bit positions of the word offset, line index and tag within a byte address.
    localparam int unsigned WORD_LSB  = WORD_BYTES_WIDTH;
    localparam int unsigned INDEX_LSB = WORD_BYTES_WIDTH + LINE_WORDS_WIDTH;
    localparam int unsigned TAG_LSB   = INDEX_LSB + LINE_INDEX_WIDTH;

    typedef logic [ADDR_BITS-1:0]        addr_t;
    typedef logic [WORD_BITS-1:0]        data_t;
    typedef logic [TAG_BITS-1:0]         tag_t;
    typedef logic [LINE_INDEX_WIDTH-1:0] idx_t;
    typedef logic [LINE_WORDS_WIDTH-1:0] word_t;

    localparam word_t LAST_WORD = '1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBack = 2'd1,
        StFill = 2'd2,
        StWait = 2'd3
    } state_e;

    // Word-aligned byte address of one word of a line.
    function automatic addr_t line_addr(input tag_t tag, input idx_t idx, input word_t word);
        return {tag, idx, word, {WORD_BYTES_WIDTH{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: CPU load/store port, cache array port and memory bus seen by the
// cache controller. master = controller side, slave = CPU/array/memory side.
interface cache_ctrl_if;
    import cache_pkg::*;

    logic  cpu_en;
    logic  cpu_we;
    addr_t cpu_addr;
    data_t cpu_din;
    data_t cpu_dout;
    logic  cpu_stall;

    addr_t cache_addr;
    data_t cache_din;
    logic  cache_store;
    logic  cache_edit;
    logic  cache_invalid;
    logic  cache_hit;
    logic  cache_valid;
    logic  cache_dirty;
    tag_t  cache_tag;
    data_t cache_dout;

    logic  mem_cs;
    logic  mem_we;
    addr_t mem_addr;
    data_t mem_din;
    data_t mem_dout;
    logic  mem_ack;

    modport master (
        input  cpu_en, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_stall,
        output cache_addr, cache_din, cache_store, cache_edit, cache_invalid,
        input  cache_hit, cache_valid, cache_dirty, cache_tag, cache_dout,
        output mem_cs, mem_we, mem_addr, mem_din,
        input  mem_dout, mem_ack
    );

    modport slave (
        output cpu_en, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_stall,
        input  cache_addr, cache_din, cache_store, cache_edit, cache_invalid,
        output cache_hit, cache_valid, cache_dirty, cache_tag, cache_dout,
        input  mem_cs, mem_we, mem_addr, mem_din,
        output mem_dout, mem_ack
    );

endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped write-back cache sequencer. Hit detection in IDLE,
// dirty-victim write-back (BACK), line refill (FILL) and a one-cycle re-lookup (WAIT).
// Optional macro CACHE_CTRL_STAT_EN adds saturating hit/miss counters.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    cache_ctrl_if.master      bus
`ifdef CACHE_CTRL_STAT_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);

    state_e state_q;
    word_t  cnt_q;
    tag_t   tag_q;
    idx_t   idx_q;
    logic   we_q;
    logic   retry_q;
    logic   mem_cs_q;
    logic   mem_we_q;
    addr_t  mem_addr_q;

    logic   busy;
    logic   miss;
    logic   eff_we;
    logic   fill_ack;
    word_t  cnt_nxt;
    tag_t   cpu_tag;
    idx_t   cpu_idx;

    assign cpu_tag = bus.cpu_addr[TAG_LSB +: TAG_BITS];
    assign cpu_idx = bus.cpu_addr[INDEX_LSB +: LINE_INDEX_WIDTH];
    assign cnt_nxt = cnt_q + 1'b1;

    assign busy     = (state_q == StBack) || (state_q == StFill);
    assign miss     = (state_q == StIdle) && bus.cpu_en && !bus.cache_hit;
    assign fill_ack = (state_q == StFill) && bus.mem_ack;
    // The re-lookup after a refill uses the write-enable captured at the miss.
    assign eff_we   = retry_q ? we_q : bus.cpu_we;

    // Array, CPU and memory-bus datapath selects.
    always_comb begin
        bus.cpu_stall     = (state_q != StIdle) || miss;
        bus.cpu_dout      = bus.cache_dout;
        bus.cache_addr    = busy ? mem_addr_q : bus.cpu_addr;
        bus.cache_din     = (state_q == StFill) ? bus.mem_dout : bus.cpu_din;
        bus.cache_store   = fill_ack;
        bus.cache_edit    = fill_ack ||
                            ((state_q == StIdle) && bus.cpu_en && bus.cache_hit && eff_we);
        bus.cache_invalid = 1'b0;
        bus.mem_cs        = mem_cs_q;
        bus.mem_we        = mem_we_q;
        bus.mem_addr      = mem_addr_q;
        bus.mem_din       = bus.cache_dout;
    end

    // Controller FSM with word counter and registered memory-bus request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tag_q      <= '0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            retry_q    <= 1'b0;
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    retry_q <= 1'b0;
                    if (miss) begin
                        tag_q    <= cpu_tag;
                        idx_q    <= cpu_idx;
                        we_q     <= bus.cpu_we;
                        cnt_q    <= '0;
                        mem_cs_q <= 1'b1;
                        if (bus.cache_valid && bus.cache_dirty) begin
                            state_q    <= StBack;
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= line_addr(bus.cache_tag, cpu_idx, '0);
                        end else begin
                            state_q    <= StFill;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= line_addr(cpu_tag, cpu_idx, '0);
                        end
                    end
                end
                StBack: begin
                    if (bus.mem_ack) begin
                        cnt_q <= cnt_nxt;
                        if (cnt_q == LAST_WORD) begin
                            state_q    <= StFill;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= line_addr(tag_q, idx_q, '0);
                        end else begin
                            // Victim tag lives in the address register for the whole burst.
                            mem_addr_q <= line_addr(mem_addr_q[TAG_LSB +: TAG_BITS], idx_q,
                                                    cnt_nxt);
                        end
                    end
                end
                StFill: begin
                    if (bus.mem_ack) begin
                        cnt_q <= cnt_nxt;
                        if (cnt_q == LAST_WORD) begin
                            state_q  <= StWait;
                            mem_cs_q <= 1'b0;
                        end else begin
                            mem_addr_q <= line_addr(tag_q, idx_q, cnt_nxt);
                        end
                    end
                end
                StWait: begin
                    state_q <= StIdle;
                    retry_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef CACHE_CTRL_STAT_EN
    logic accepted;
    assign accepted = (state_q == StIdle) && bus.cpu_en && !retry_q;

    // Saturating per-access hit/miss counters; the post-refill retry is not recounted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (accepted) begin
            if (bus.cache_hit && (stat_hits != '1)) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (!bus.cache_hit && (stat_misses != '1)) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed bench for cache_ctrl with a behavioural cache array and a
// word-wide memory responder with programmable ack latency.
module tb_cache_ctrl;
    import cache_pkg::*;

    logic clk;
    logic rst_n;
    cache_ctrl_if bus ();

`ifdef CACHE_CTRL_STAT_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    cache_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus)
`ifdef CACHE_CTRL_STAT_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural cache array, indexed by cache_addr.
    logic [63:0] arr_valid = '0;
    logic [63:0] arr_dirty = '0;
    tag_t        arr_tag  [64];
    data_t       arr_data [64][4];

    idx_t  a_idx;
    word_t a_word;
    tag_t  a_tag;
    assign a_idx  = bus.cache_addr[INDEX_LSB +: LINE_INDEX_WIDTH];
    assign a_word = bus.cache_addr[WORD_LSB +: LINE_WORDS_WIDTH];
    assign a_tag  = bus.cache_addr[TAG_LSB +: TAG_BITS];

    assign bus.cache_valid = arr_valid[a_idx];
    assign bus.cache_dirty = arr_dirty[a_idx];
    assign bus.cache_tag   = arr_tag[a_idx];
    assign bus.cache_hit   = arr_valid[a_idx] && (arr_tag[a_idx] == a_tag);
    assign bus.cache_dout  = arr_data[a_idx][a_word];

    always @(posedge clk) begin
        if (bus.cache_store) begin
            arr_valid[a_idx]         <= 1'b1;
            arr_dirty[a_idx]         <= 1'b0;
            arr_tag[a_idx]           <= a_tag;
            arr_data[a_idx][a_word]  <= bus.cache_din;
        end else if (bus.cache_edit) begin
            arr_data[a_idx][a_word]  <= bus.cache_din;
            arr_dirty[a_idx]         <= 1'b1;
        end
    end

    // Memory image: lines with address bit 22 set hold 0xB0.., others 0xA0..
    function automatic data_t mem_image(input addr_t a);
        data_t base;
        base = a[22] ? 32'h0000_00B0 : 32'h0000_00A0;
        return base + {30'd0, a[3:2]};
    endfunction

    int    mem_delay = 0;
    int    wait_cnt  = 0;
    int    ack_total = 0;
    int    wr_n      = 0;
    int    rd_n      = 0;
    addr_t wr_addr [32];
    data_t wr_data [32];
    addr_t rd_addr [32];

    // Memory responder: ack after mem_delay idle request cycles, one-cycle pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_ack  <= 1'b0;
            bus.mem_dout <= '0;
            wait_cnt     <= 0;
        end else begin
            if (bus.mem_ack) ack_total <= ack_total + 1;
            bus.mem_ack <= 1'b0;
            if (bus.mem_cs && !bus.mem_ack) begin
                if (wait_cnt >= mem_delay) begin
                    bus.mem_ack <= 1'b1;
                    wait_cnt    <= 0;
                    if (bus.mem_we) begin
                        if (wr_n < 32) begin
                            wr_addr[wr_n] <= bus.mem_addr;
                            wr_data[wr_n] <= bus.mem_din;
                        end
                        wr_n <= wr_n + 1;
                    end else begin
                        bus.mem_dout <= mem_image(bus.mem_addr);
                        if (rd_n < 32) rd_addr[rd_n] <= bus.mem_addr;
                        rd_n <= rd_n + 1;
                    end
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end else begin
                wait_cnt <= 0;
            end
        end
    end

    initial begin
        int    n;
        int    rd0;
        int    wr0;
        int    ack0;
        logic  saw_back;
        logic  unstable;
        logic  prev_cs;
        logic  prev_ack;
        addr_t prev_addr;

        rst_n        = 1'b0;
        bus.cpu_en   = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_din  = '0;
        repeat (3) @(negedge clk);
        check("rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check("rst_mem_cs", {31'd0, bus.mem_cs}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_strobes", {29'd0, bus.cache_store, bus.cache_edit, bus.cache_invalid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Load miss on a clean line: FILL only.
        rd0 = rd_n;
        wr0 = wr_n;
        bus.cpu_en   = 1'b1;
        bus.cpu_addr = 32'h0000_1040;
        #1;
        check("miss_stall_same_cycle", {31'd0, bus.cpu_stall}, 32'd1);
        n = 0;
        saw_back = 1'b0;
        while (bus.cpu_stall && n < 100) begin
            @(negedge clk);
            if (bus.mem_cs && bus.mem_we) saw_back = 1'b1;
            n++;
        end
        check("fill1_timeout", {31'd0, n < 100}, 32'd1);
        check("fill1_no_back", {31'd0, saw_back}, 32'd0);
        check("fill1_no_writes", wr_n - wr0, 32'd0);
        check("fill1_reads", rd_n - rd0, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill1_addr%0d", i), rd_addr[rd0 + i], 32'h0000_1040 + 4 * i);
        end
        check("fill1_dout", bus.cpu_dout, 32'h0000_00A0);
        check("fill1_mem_cs_off", {31'd0, bus.mem_cs}, 32'd0);
        bus.cpu_en = 1'b0;
        @(negedge clk);

        // Load hit.
        bus.cpu_en   = 1'b1;
        bus.cpu_addr = 32'h0000_1044;
        #1;
        check("hit_ld_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check("hit_ld_dout", bus.cpu_dout, 32'h0000_00A1);
        check("hit_ld_mem_cs", {31'd0, bus.mem_cs}, 32'd0);
        @(negedge clk);
        bus.cpu_en = 1'b0;
        @(negedge clk);

        // Store hit.
        bus.cpu_en   = 1'b1;
        bus.cpu_we   = 1'b1;
        bus.cpu_addr = 32'h0000_1048;
        bus.cpu_din  = 32'hDEAD_BEEF;
        #1;
        check("hit_st_edit", {31'd0, bus.cache_edit}, 32'd1);
        check("hit_st_store", {31'd0, bus.cache_store}, 32'd0);
        check("hit_st_din", bus.cache_din, 32'hDEAD_BEEF);
        check("hit_st_stall", {31'd0, bus.cpu_stall}, 32'd0);
        @(negedge clk);
        bus.cpu_en = 1'b0;
        bus.cpu_we = 1'b0;
        #1;
        check("hit_st_edit_pulse", {31'd0, bus.cache_edit}, 32'd0);
        check("hit_st_array", arr_data[4][2], 32'hDEAD_BEEF);
        @(negedge clk);

        // Conflict miss on a dirty line with slow memory: BACK then FILL.
        mem_delay = 5;
        rd0  = rd_n;
        wr0  = wr_n;
        ack0 = ack_total;
        bus.cpu_en   = 1'b1;
        bus.cpu_addr = 32'h0040_1040;
        #1;
        check("miss2_stall", {31'd0, bus.cpu_stall}, 32'd1);
        n = 0;
        unstable  = 1'b0;
        prev_cs   = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = '0;
        while (bus.cpu_stall && n < 400) begin
            @(negedge clk);
            if (bus.mem_cs && prev_cs && !prev_ack && (bus.mem_addr != prev_addr)) begin
                unstable = 1'b1;
            end
            prev_cs   = bus.mem_cs;
            prev_ack  = bus.mem_ack;
            prev_addr = bus.mem_addr;
            n++;
        end
        check("miss2_timeout", {31'd0, n < 400}, 32'd1);
        check("miss2_addr_stable", {31'd0, unstable}, 32'd0);
        check("miss2_slow_burst", {31'd0, n > 48}, 32'd1);
        check("miss2_acks", ack_total - ack0, 32'd8);
        check("back_writes", wr_n - wr0, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("back_addr%0d", i), wr_addr[wr0 + i], 32'h0000_1040 + 4 * i);
        end
        check("back_data0", wr_data[wr0 + 0], 32'h0000_00A0);
        check("back_data1", wr_data[wr0 + 1], 32'h0000_00A1);
        check("back_data2", wr_data[wr0 + 2], 32'hDEAD_BEEF);
        check("back_data3", wr_data[wr0 + 3], 32'h0000_00A3);
        check("fill2_reads", rd_n - rd0, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill2_addr%0d", i), rd_addr[rd0 + i], 32'h0040_1040 + 4 * i);
        end
        check("fill2_dout", bus.cpu_dout, 32'h0000_00B0);
        bus.cpu_en = 1'b0;
        @(negedge clk);
        check("fill2_clean", {31'd0, arr_dirty[4]}, 32'd0);

`ifdef CACHE_CTRL_STAT_EN
        check("stat_hits", stat_hits, 32'd2);
        check("stat_misses", stat_misses, 32'd2);
`endif

        // Reset in the middle of a refill.
        mem_delay = 0;
        ack0 = ack_total;
        bus.cpu_en   = 1'b1;
        bus.cpu_addr = 32'h0000_2080;
        n = 0;
        while ((ack_total - ack0) < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midfill_timeout", {31'd0, n < 50}, 32'd1);
        check("midfill_busy", {31'd0, bus.mem_cs}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midfill_rst_mem_cs", {31'd0, bus.mem_cs}, 32'd0);
        check("midfill_rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("midfill_rst_mem_addr", bus.mem_addr, 32'd0);
        check("midfill_rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check("midfill_partial_word1", arr_data[8][1], 32'h0000_00A1);
        bus.cpu_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_mem_cs", {31'd0, bus.mem_cs}, 32'd0);
        check("post_rst_stall", {31'd0, bus.cpu_stall}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
